// File: rtl/l2_pmem_responder.sv
// l2_pmem_responder: line-addressed backing store below the L2 with modelled DRAM latency.
// Optional open-row latency model enabled by defining PMEM_ROW_BUFFER_EN.
module l2_pmem_responder #(
    parameter int LINE_BITS      = 256,
    parameter int OFFSET_BITS    = 5,
    parameter int DEPTH_LOG2     = 10,
    parameter int ROW_LINES_LOG2 = 3,
    parameter int MISS_LATENCY   = 20,
    parameter int HIT_LATENCY    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [31:0]          pmem_address,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 pmem_resp
);

    localparam int CNT_W = $clog2(MISS_LATENCY);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [LINE_BITS-1:0]  r_mem [DEPTH];
    logic [LINE_BITS-1:0]  r_wdata;
    logic [LINE_BITS-1:0]  r_rdata;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_load;
    logic                  r_is_wr;
    logic                  w_req;
    logic                  w_accept;
    logic                  w_hit;
    logic                  w_resp;
    logic                  w_unused;

    assign w_idx    = pmem_address[OFFSET_BITS+DEPTH_LOG2-1:OFFSET_BITS];
    assign w_req    = pmem_read | pmem_write;
    assign w_accept = (r_state == S_IDLE) && w_req;
    assign w_unused = ^{pmem_address[31:OFFSET_BITS+DEPTH_LOG2],
                        pmem_address[OFFSET_BITS-1:0]};

`ifdef PMEM_ROW_BUFFER_EN
    localparam int ROW_W = DEPTH_LOG2 - ROW_LINES_LOG2;

    logic [ROW_W-1:0] r_open_row;
    logic             r_row_vld;
    logic [ROW_W-1:0] w_row;

    assign w_row = w_idx[DEPTH_LOG2-1:ROW_LINES_LOG2];
    assign w_hit = r_row_vld && (r_open_row == w_row);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_open_row <= '0;
            r_row_vld  <= 1'b0;
        end else if (w_accept) begin
            r_open_row <= w_row;
            r_row_vld  <= 1'b1;
        end
    end
`else
    localparam int p_unused_row_lines = ROW_LINES_LOG2;

    assign w_hit = 1'b0;
`endif

    // Counter holds L-2 so that the response lands exactly L cycles after acceptance.
    assign w_load = w_hit ? CNT_W'(HIT_LATENCY - 2)
                          : CNT_W'(MISS_LATENCY - 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
                w_resp = !rst;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_is_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_wr <= pmem_write;
                        r_idx   <= w_idx;
                        r_wdata <= pmem_wdata;
                        r_cnt   <= w_load;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_is_wr) begin
                        r_rdata <= r_mem[r_idx];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Commit at the edge ending RESP; a reset in that cycle drops the write.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_RESP) && r_is_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign pmem_resp  = w_resp;
    assign pmem_rdata = r_rdata;

endmodule

// File: tb/tb_l2_pmem_responder.sv
// Bench for l2_pmem_responder: directed traffic, per-cycle reference model
// and literal latency/data expectations.
module tb_l2_pmem_responder;

    localparam int LMISS = 20;
`ifdef PMEM_ROW_BUFFER_EN
    localparam bit ROWBUF = 1'b1;
    localparam int RB_HIT = 6;
`else
    localparam bit ROWBUF = 1'b0;
    localparam int RB_HIT = 20;
`endif

    logic         clk;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    l2_pmem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: spec-level view (acceptance cycle + latency = due cycle).
    logic [255:0] m_mem [1024];
    logic [255:0] m_wd;
    logic [255:0] m_rdata;
    bit           m_busy;
    bit           m_wr;
    bit           m_row_vld;
    bit           m_live;
    int           m_idx;
    int           m_row;
    int           m_due;
    int           cyc;

    initial begin
        logic exp_resp;
        int   row;
        int   lat;
        for (int i = 0; i < 1024; i++) m_mem[i] = '0;
        m_rdata = '0;
        m_wd = '0;
        m_busy = 0;
        m_wr = 0;
        m_row_vld = 0;
        m_live = 0;
        m_idx = 0;
        m_row = 0;
        m_due = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (m_busy && cyc == m_due && !m_wr) m_rdata = m_mem[m_idx];
            exp_resp = m_busy && (cyc == m_due) && !rst;
            if (m_live) begin
                chk("model_resp", 256'(pmem_resp), 256'(exp_resp));
                chk("model_rdata", pmem_rdata, m_rdata);
            end
            if (rst) begin
                m_busy = 0;
                m_rdata = '0;
                m_row_vld = 0;
                m_live = 1;
            end else if (m_busy) begin
                if (cyc == m_due) begin
                    if (m_wr) m_mem[m_idx] = m_wd;
                    m_busy = 0;
                end
            end else if (pmem_read || pmem_write) begin
                m_idx = int'((pmem_address >> 5) & 32'h3FF);
                row = m_idx / 8;
                lat = (ROWBUF && m_row_vld && row == m_row) ? 6 : 20;
                m_row = row;
                m_row_vld = 1;
                m_wr = pmem_write;
                m_wd = pmem_wdata;
                m_due = cyc + lat;
                m_busy = 1;
            end
            cyc++;
        end
    end

    task automatic do_req(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [255:0] wd,
                          output int lat, output logic [255:0] rdat);
        @(posedge clk);
        #1;
        pmem_read = rd;
        pmem_write = wr;
        pmem_address = a;
        pmem_wdata = wd;
        lat = -1;
        rdat = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (pmem_resp) begin
                lat = k;
                rdat = pmem_rdata;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout addr=%h actual=none required=resp", a);
        end
    endtask

    task automatic drop();
        @(posedge clk);
        #1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int           lat;
        logic [255:0] rd;
        logic [255:0] pat_aa;
        logic [255:0] pat_11;
        logic [255:0] pat_55;
        logic [255:0] pat_77;
        logic [255:0] pat_cc;
        bit           saw;
        pat_aa = {32{8'hAA}};
        pat_11 = {32{8'h11}};
        pat_55 = {32{8'h55}};
        pat_77 = {32{8'h77}};
        pat_cc = {32{8'hCC}};
        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_address = '0;
        pmem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_resp", 256'(pmem_resp), 256'(0));
        chk("reset_rdata", pmem_rdata, '0);

        do_req(1'b0, 1'b1, 32'h40, pat_aa, lat, rd);
        chk("t1_wr_lat", 256'(lat), 256'(LMISS));
        do_req(1'b1, 1'b0, 32'h40, '0, lat, rd);
        chk("t1_rd_lat", 256'(lat), 256'(RB_HIT));
        chk("t1_rd_data", rd, pat_aa);
        drop();

        do_reset();
        do_req(1'b1, 1'b0, 32'h0, '0, lat, rd);
        chk("t2_lat0", 256'(lat), 256'(LMISS));
        do_req(1'b1, 1'b0, 32'h20, '0, lat, rd);
        chk("t2_lat1", 256'(lat), 256'(RB_HIT));
        do_req(1'b1, 1'b0, 32'h1000, '0, lat, rd);
        chk("t2_lat2", 256'(lat), 256'(LMISS));
        drop();

        do_req(1'b0, 1'b1, 32'h80, pat_11, lat, rd);
        chk("t3_wr_lat", 256'(lat), 256'(LMISS));
        do_req(1'b1, 1'b0, 32'h80, '0, lat, rd);
        chk("t3_b2b_lat", 256'(lat), 256'(RB_HIT));
        chk("t3_rd_data", rd, pat_11);
        drop();

        do_req(1'b1, 1'b1, 32'h100, pat_55, lat, rd);
        chk("t4_no_read", rd, pat_11);
        drop();
        do_req(1'b1, 1'b0, 32'h100, '0, lat, rd);
        chk("t4_rd_data", rd, pat_55);
        drop();

        @(posedge clk);
        #1;
        pmem_write = 1'b1;
        pmem_address = 32'h200;
        pmem_wdata = pat_77;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        pmem_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        saw = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (pmem_resp) saw = 1;
        end
        chk("t5_no_resp", 256'(saw), 256'(0));
        chk("t5_rdata_clr", pmem_rdata, '0);
        do_req(1'b1, 1'b0, 32'h200, '0, lat, rd);
        chk("t5_old_data", rd, '0);
        drop();

        do_req(1'b0, 1'b1, 32'h8040, pat_cc, lat, rd);
        drop();
        do_req(1'b1, 1'b0, 32'h40, '0, lat, rd);
        chk("t6_alias", rd, pat_cc);
        drop();

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
